// File: rtl/nor4_char_seq.sv
// nor4_char_seq: characterisation sequencer for a single NOR4 cell under test.
// Latency: N*ITER*(SETTLE_CYC+2) cycles from accepted start to done (N = 16/4/15/16 by mode).
// Backpressure: none; start is only honoured in IDLE, anything else is dropped while busy.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   start      one-cycle run request (sampled only in IDLE)
//   mode[1:0]  sequence select, latched on accepted start
//                00 exhaustive, 01 walking one, 10 LFSR, 11 toggle 0000/0001
//   qn         output of the NOR4 cell under test
//   drv[3:0]   registered drive to the cell, drv[0..3] -> IN1..IN4
//   busy       high while a run is in progress
//   done       one-cycle pulse at end of run
//   tog_cnt    sampled qn transitions in the run (saturating)
//   err_cnt    sampled qn values not equal to ~|drv (saturating)
//   first_err  {valid, vector} of the first mismatch of the run
//
// Build option: define NOR4_CHAR_ERRLOG_EN to enable first_err capture;
// without it first_err is constant zero.

module nor4_char_seq #(
  parameter int unsigned SETTLE_CYC = 2,   // 1..15
  parameter int unsigned ITER       = 1    // 1..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic        qn,
  output logic [3:0]  drv,
  output logic        busy,
  output logic        done,
  output logic [15:0] tog_cnt,
  output logic [7:0]  err_cnt,
  output logic [4:0]  first_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    FIN    = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [7:0] ITER_LAST   = 8'(ITER - 1);

  state_t      state;
  state_t      state_nxt;

  logic [1:0]  mode_q;
  logic [3:0]  vec_idx;
  logic [7:0]  pass_cnt;
  logic [3:0]  settle_cnt;
  logic        prev_qn;
  logic        have_prev;

  logic        last_vec;
  logic        last_pass;
  logic        settle_done;
  logic        mismatch;
  logic        toggled;
  logic        active_nxt;

  // Index of the final vector of one pass for each sequence.
  function automatic logic [3:0] last_idx(input logic [1:0] m);
    case (m)
      2'b01:   last_idx = 4'd3;
      2'b10:   last_idx = 4'd14;
      default: last_idx = 4'd15;
    endcase
  endfunction

  function automatic logic [3:0] first_vec(input logic [1:0] m);
    case (m)
      2'b01, 2'b10: first_vec = 4'b0001;
      default:      first_vec = 4'b0000;
    endcase
  endfunction

  // Successor within a pass. The LFSR shifts left with feedback bit3^bit0,
  // which walks all 15 non-zero states starting from 0001.
  function automatic logic [3:0] next_vec(input logic [1:0] m, input logic [3:0] v);
    case (m)
      2'b00:   next_vec = v + 4'd1;
      2'b01:   next_vec = {v[2:0], v[3]};
      2'b10:   next_vec = {v[2:0], v[3] ^ v[0]};
      default: next_vec = v ^ 4'b0001;
    endcase
  endfunction

  assign last_vec    = (vec_idx == last_idx(mode_q));
  assign last_pass   = (pass_cnt == ITER_LAST);
  assign settle_done = (settle_cnt == SETTLE_LAST);
  assign mismatch    = (qn != ~|drv);
  // The first sample of a run has no predecessor, so it never counts.
  assign toggled     = have_prev && (qn != prev_qn);
  assign active_nxt  = (state_nxt == DRIVE) || (state_nxt == SETTLE) || (state_nxt == SAMPLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   state_nxt = SETTLE;
      SETTLE:  if (settle_done) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (last_vec && last_pass) ? FIN : DRIVE;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: vector generation, counters and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= 2'b00;
      vec_idx    <= 4'd0;
      pass_cnt   <= 8'd0;
      settle_cnt <= 4'd0;
      prev_qn    <= 1'b0;
      have_prev  <= 1'b0;
      drv        <= 4'b0000;
      busy       <= 1'b0;
      done       <= 1'b0;
      tog_cnt    <= 16'd0;
      err_cnt    <= 8'd0;
    end else begin
      // Flags are registered off the next state so they line up with it.
      busy <= active_nxt;
      done <= (state_nxt == FIN);

      case (state)
        IDLE: begin
          drv <= 4'b0000;
          if (start) begin
            mode_q    <= mode;
            vec_idx   <= 4'd0;
            pass_cnt  <= 8'd0;
            have_prev <= 1'b0;
            tog_cnt   <= 16'd0;
            err_cnt   <= 8'd0;
            drv       <= first_vec(mode);
          end
        end

        DRIVE: begin
          settle_cnt <= 4'd0;
        end

        SETTLE: begin
          settle_cnt <= settle_cnt + 4'd1;
        end

        SAMPLE: begin
          prev_qn   <= qn;
          have_prev <= 1'b1;
          if (mismatch && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
          end
          if (toggled && (tog_cnt != 16'hFFFF)) begin
            tog_cnt <= tog_cnt + 16'd1;
          end

          if (last_vec && last_pass) begin
            drv <= 4'b0000;
          end else if (last_vec) begin
            // Pass boundary: restart the sequence, keep the sample history.
            vec_idx  <= 4'd0;
            pass_cnt <= pass_cnt + 8'd1;
            drv      <= first_vec(mode_q);
          end else begin
            vec_idx <= vec_idx + 4'd1;
            drv     <= next_vec(mode_q, drv);
          end
        end

        FIN: begin
          drv <= 4'b0000;
        end

        default: begin
          drv <= 4'b0000;
        end
      endcase
    end
  end

`ifdef NOR4_CHAR_ERRLOG_EN
  // Capture the vector of the first mismatch; the valid bit locks it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_err <= 5'd0;
    end else if ((state == IDLE) && start) begin
      first_err <= 5'd0;
    end else if ((state == SAMPLE) && mismatch && !first_err[4]) begin
      first_err <= {1'b1, drv};
    end
  end
`else
  assign first_err = 5'd0;
`endif

endmodule
